// File: rtl/ilog2_pipe.sv
// Pipelined floor-log2 with valid/ready backpressure, zero flag and sideband tag.
// Define ILOG2_CEIL_EN to add the sticky-bit tracking and the out_ceil port.
module ilog2_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] out_log2,
    output logic                     out_zero,
    output logic [TAG_W-1:0]         out_tag
`ifdef ILOG2_CEIL_EN
    ,
    output logic [$clog2(WIDTH):0]   out_ceil
`endif
);

    localparam int unsigned LW = $clog2(WIDTH);
    localparam int unsigned NS = LW - 2;            // total stages
    localparam int unsigned NH = LW - 3;            // halving stages
    localparam int unsigned ND = (NH > 0) ? NH : 1;

    function automatic logic [2:0] flog8(input logic [7:0] v);
        flog8 = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (v[i]) flog8 = 3'(i);
        end
    endfunction

    logic [WIDTH-1:0] data_q [ND];
    logic [WIDTH-1:0] data_d [ND];
    logic [LW-1:0]    log_q  [NS];
    logic [LW-1:0]    log_d  [NS];
    logic [TAG_W-1:0] tag_q  [NS];
    logic [TAG_W-1:0] tag_d  [NS];
    logic [NS-1:0]    zero_q, zero_d, vld_q, vld_d;

    // Per-stage inputs: index 0 is the operand entry, index k is stage k-1's register.
    logic [WIDTH-1:0] src_data [NS];
    logic [LW-1:0]    src_log  [NS];
    logic [TAG_W-1:0] src_tag  [NS];
    logic [NS-1:0]    src_zero, src_vld;
    logic [WIDTH-1:0] hi, lo;
    logic [7:0]       tv;
    logic [2:0]       tf;
    logic             adv;

`ifdef ILOG2_CEIL_EN
    logic [NS-1:0]    stk_q, stk_d, src_stk;
`endif

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv | reset;

    always_comb begin
        hi = '0;
        lo = '0;
        src_data[0] = in_data;
        src_log[0]  = '0;
        src_tag[0]  = in_tag;
        src_zero[0] = (in_data == '0);
        src_vld[0]  = in_valid;
`ifdef ILOG2_CEIL_EN
        src_stk[0]  = 1'b0;
`endif
        for (int unsigned k = 1; k < NS; k++) begin
            src_data[k] = data_q[k-1];
            src_log[k]  = log_q[k-1];
            src_tag[k]  = tag_q[k-1];
            src_zero[k] = zero_q[k-1];
            src_vld[k]  = vld_q[k-1];
`ifdef ILOG2_CEIL_EN
            src_stk[k]  = stk_q[k-1];
`endif
        end
        for (int unsigned k = 0; k < ND; k++) begin
            data_d[k] = '0;
        end
        for (int unsigned k = 0; k < NS; k++) begin
            tag_d[k]  = src_tag[k];
            zero_d[k] = src_zero[k];
            vld_d[k]  = src_vld[k];
        end
        // Halving stage k keeps whichever half holds the leading one.
        for (int unsigned k = 0; k < NH; k++) begin
            hi = src_data[k] >> (WIDTH >> (k + 1));
            lo = src_data[k] ^ (hi << (WIDTH >> (k + 1)));
            if (hi != '0) begin
                data_d[k] = hi;
                log_d[k]  = src_log[k] + LW'(WIDTH >> (k + 1));
            end else begin
                data_d[k] = lo;
                log_d[k]  = src_log[k];
            end
`ifdef ILOG2_CEIL_EN
            stk_d[k] = src_stk[k] | ((hi != '0) && (lo != '0));
`endif
        end
        tv = src_data[NH][7:0];
        tf = flog8(tv);
        log_d[NS-1] = src_log[NH] + LW'(tf);
`ifdef ILOG2_CEIL_EN
        stk_d[NS-1] = src_stk[NH] | ((tv & ((8'h1 << tf) - 8'h1)) != 8'h0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            zero_q <= '0;
`ifdef ILOG2_CEIL_EN
            stk_q  <= '0;
`endif
            for (int unsigned k = 0; k < ND; k++) data_q[k] <= '0;
            for (int unsigned k = 0; k < NS; k++) begin
                log_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q  <= vld_d;
            zero_q <= zero_d;
`ifdef ILOG2_CEIL_EN
            stk_q  <= stk_d;
`endif
            data_q <= data_d;
            log_q  <= log_d;
            tag_q  <= tag_d;
        end
    end

    assign out_valid = vld_q[NS-1];
    assign out_log2  = log_q[NS-1];
    assign out_zero  = zero_q[NS-1];
    assign out_tag   = tag_q[NS-1];
`ifdef ILOG2_CEIL_EN
    assign out_ceil  = {1'b0, log_q[NS-1]} + (LW+1)'(stk_q[NS-1] & ~zero_q[NS-1]);
`endif

endmodule
